// File: rtl/gp_pkg.sv
// Shared GP-Core divider types: FSM states and the {is_signed, rem_sel} op encoding.
package gp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFix,
    StDone
  } div_state_e;

  // Op encoding driven by the decoder onto {is_signed, rem_sel}.
  typedef enum logic [1:0] {
    DIV_Q_U = 2'b00,
    DIV_R_U = 2'b01,
    DIV_Q_S = 2'b10,
    DIV_R_S = 2'b11
  } div_op_e;

endpackage

// File: rtl/gp_div_step.sv
// One radix-2 restoring step: shift {rem, quot} left, trial-subtract the divisor magnitude.
module gp_div_step #(
  parameter int unsigned Width = 32
) (
  input  logic [Width:0]   rem_i,
  input  logic [Width-1:0] quot_i,
  input  logic [Width-1:0] divisor_i,
  output logic [Width:0]   rem_o,
  output logic [Width-1:0] quot_o
);

  logic [Width+1:0] shifted;
  logic [Width+1:0] diff;
  logic             fits;

  // One spare bit above the partial remainder keeps the borrow unambiguous.
  always_comb begin
    shifted = {rem_i, quot_i[Width-1]};
    diff    = shifted - {2'b00, divisor_i};
    fits    = ~diff[Width+1];
    rem_o   = fits ? diff[Width:0] : shifted[Width:0];
    quot_o  = {quot_i[Width-2:0], fits};
  end

endmodule

// File: rtl/gp_divider.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) with valid/ready handshakes on both sides.
module gp_divider
  import gp_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  input  logic             rem_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             rem_sel_q, rem_sel_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             ovf_cand_q, ovf_cand_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quot;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  gp_div_step #(
    .Width(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .quot_i   (quot_q),
    .divisor_i(dvsr_q),
    .rem_o    (step_rem),
    .quot_o   (step_quot)
  );

  assign in_ready    = (state_q == StIdle) && rst_n;
  assign out_valid   = (state_q == StDone);
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    rem_sel_d  = rem_sel_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    ovf_cand_d = ovf_cand_q;
    result_d   = result_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    a_neg      = is_signed & dividend[WIDTH-1];
    b_neg      = is_signed & divisor[WIDTH-1];
    quot_fix   = q_neg_q ? -quot_q : quot_q;
    rem_fix    = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          rem_sel_d  = rem_sel;
          q_neg_d    = a_neg ^ b_neg;
          r_neg_d    = a_neg;
          // Negating the most-negative value leaves its bit pattern, which is its magnitude.
          quot_d     = a_neg ? -dividend : dividend;
          dvsr_d     = b_neg ? -divisor : divisor;
          rem_d      = '0;
          ovf_cand_d = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
          count_d    = '0;
          if (divisor == '0) begin
            result_d = rem_sel ? dividend : '1;
            dbz_d    = 1'b1;
            ovf_d    = 1'b0;
            state_d  = StDone;
          end else begin
            state_d = StIter;
          end
        end
      end
      StIter: begin
        rem_d   = step_rem;
        quot_d  = step_quot;
        count_d = count_q + 1'b1;
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        result_d = rem_sel_q ? rem_fix : quot_fix;
        dbz_d    = 1'b0;
        ovf_d    = ovf_cand_q;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      rem_sel_q  <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      ovf_cand_q <= 1'b0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      rem_sel_q  <= rem_sel_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      ovf_cand_q <= ovf_cand_d;
      result_q   <= result_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_gp_divider.sv
// Directed-vector bench for gp_divider (WIDTH=32) plus an isolated gp_div_step check.
module tb_gp_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        rem_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div_by_zero;
  logic        overflow;

  logic [32:0] st_rem_i, st_rem_o;
  logic [31:0] st_quot_i, st_quot_o, st_dvsr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gp_divider #(
    .WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .is_signed  (is_signed),
    .rem_sel    (rem_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  gp_div_step #(
    .Width(32)
  ) u_step_chk (
    .rem_i    (st_rem_i),
    .quot_i   (st_quot_i),
    .divisor_i(st_dvsr),
    .rem_o    (st_rem_o),
    .quot_o   (st_quot_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, waits for the result, then completes the output handshake.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic r, output logic [31:0] res, output logic dbz,
                        output logic ovf, output int lat);
    int waitc = 0;
    while (!in_ready && waitc < 100) begin
      tick();
      waitc++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
    end
    dividend  = a;
    divisor   = b;
    is_signed = s;
    rem_sel   = r;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0003;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1", out_valid);
    end
    res = result;
    dbz = div_by_zero;
    ovf = overflow;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready_low: got %0b required 0", in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, div_by_zero, overflow} !== 4'b1000 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: rdy/vld/dbz/ovf=%b result=%h required 1000 / 0",
               {in_ready, out_valid, div_by_zero, overflow}, result);
    end
  endtask

  task automatic test_step();
    st_rem_i  = 33'd5;
    st_quot_i = 32'h8000_0000;
    st_dvsr   = 32'd7;
    #1;
    checks++;
    if (st_rem_o !== 33'd4 || st_quot_o !== 32'h1) begin
      errors++;
      $display("FAIL step_fits: rem=%0d quot=%h required 4 / 1", st_rem_o, st_quot_o);
    end
    st_rem_i  = 33'd2;
    st_quot_i = 32'h0000_0000;
    #1;
    checks++;
    if (st_rem_o !== 33'd4 || st_quot_o !== 32'h0) begin
      errors++;
      $display("FAIL step_no_fit: rem=%0d quot=%h required 4 / 0", st_rem_o, st_quot_o);
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] res;
    logic dbz, ovf;
    int lat;
    do_div(32'd100, 32'd7, 1'b0, 1'b0, res, dbz, ovf, lat);
    checks++;
    if (res !== 32'd14 || dbz !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL divu_100_7: res=%0d dbz=%0b ovf=%0b required 14 0 0", res, dbz, ovf);
    end
    checks++;
    if (lat != 34) begin
      errors++;
      $display("FAIL latency: got %0d required 34", lat);
    end
    do_div(32'd100, 32'd7, 1'b0, 1'b1, res, dbz, ovf, lat);
    checks++;
    if (res !== 32'd2) begin
      errors++;
      $display("FAIL remu_100_7: res=%0d required 2", res);
    end
  endtask

  task automatic test_signed();
    logic [31:0] res;
    logic dbz, ovf;
    int lat;
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, res, dbz, ovf, lat);
    checks++;
    if (res !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_m7_2: res=%h required fffffffd", res);
    end
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, res, dbz, ovf, lat);
    checks++;
    if (res !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL rem_m7_2: res=%h required ffffffff", res);
    end
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, res, dbz, ovf, lat);
    checks++;
    if (res !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_7_m2: res=%h required fffffffd", res);
    end
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, res, dbz, ovf, lat);
    checks++;
    if (res !== 32'h0000_0001) begin
      errors++;
      $display("FAIL rem_7_m2: res=%h required 00000001", res);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] res;
    logic dbz, ovf;
    int lat;
    do_div(32'd5, 32'd0, 1'b0, 1'b0, res, dbz, ovf, lat);
    checks++;
    if (res !== 32'hFFFF_FFFF || dbz !== 1'b1 || ovf !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL dbz_quot: res=%h dbz=%0b ovf=%0b lat=%0d required ffffffff 1 0 1",
               res, dbz, ovf, lat);
    end
    do_div(32'd5, 32'd0, 1'b1, 1'b1, res, dbz, ovf, lat);
    checks++;
    if (res !== 32'd5 || dbz !== 1'b1 || lat != 1) begin
      errors++;
      $display("FAIL dbz_rem: res=%h dbz=%0b lat=%0d required 00000005 1 1", res, dbz, lat);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] res;
    logic dbz, ovf;
    int lat;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, res, dbz, ovf, lat);
    checks++;
    if (res !== 32'h8000_0000 || ovf !== 1'b1 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL ovf_quot: res=%h ovf=%0b dbz=%0b required 80000000 1 0", res, ovf, dbz);
    end
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, res, dbz, ovf, lat);
    checks++;
    if (res !== 32'h0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_rem: res=%h ovf=%0b required 00000000 1", res, ovf);
    end
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, res, dbz, ovf, lat);
    checks++;
    if (res !== 32'h0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL unsigned_big_quot: res=%h ovf=%0b required 00000000 0", res, ovf);
    end
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, res, dbz, ovf, lat);
    checks++;
    if (res !== 32'h8000_0000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL unsigned_big_rem: res=%h ovf=%0b required 80000000 0", res, ovf);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    logic dbz, ovf;
    int lat;
    int waitc = 0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    is_signed = 1'b0;
    rem_sel   = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    while (!out_valid && waitc < 100) begin
      tick();
      waitc++;
    end
    // A competing request while the result is parked must be ignored.
    dividend = 32'd9;
    divisor  = 32'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd14 ||
          div_by_zero !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle_%0d: vld=%0b rdy=%0b res=%0d dbz=%0b ovf=%0b required 1 0 14 0 0",
                 i, out_valid, in_ready, result, div_by_zero, overflow);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: rdy=%0b vld=%0b required 1 0", in_ready, out_valid);
    end
    do_div(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, res, dbz, ovf, lat);
    checks++;
    if (res !== 32'h0FFF_FFFF || lat != 34) begin
      errors++;
      $display("FAIL after_backpressure: res=%h lat=%0d required 0fffffff 34", res, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic dbz, ovf;
    int lat;
    dividend  = 32'd77;
    divisor   = 32'd5;
    is_signed = 1'b0;
    rem_sel   = 1'b1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: vld=%0b res=%h rdy=%0b required 0 00000000 0",
               out_valid, result, in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release: rdy=%0b vld=%0b required 1 0", in_ready, out_valid);
    end
    do_div(32'd1000, 32'd10, 1'b0, 1'b0, res, dbz, ovf, lat);
    checks++;
    if (res !== 32'd100 || lat != 34) begin
      errors++;
      $display("FAIL post_reset_div: res=%0d lat=%0d required 100 34", res, lat);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    rem_sel   = 1'b0;
    st_rem_i  = '0;
    st_quot_i = '0;
    st_dvsr   = '0;
    #1;
    test_reset();
    test_step();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
